ddr2_traffic_gen: RTL and testbench
===================================

// Module: ddr2_traffic_gen
// PURPOSE
//  Parametrised DDR2 user-interface traffic generator and checker.
//  - Writes a batch of NUM_CMDS bursts into the write-data and address FIFOs, then reads the same batch back.
//  - Regenerates the expected data and compares every returned beat.
//  - Reports sticky error plus error, first-fail and batch statistics.
//  - Sits between init_done/FIFO flags and the controller user interface, in place of the fixed 8-write/8-read test bench.
// PARAMETERS
//  DQ_WIDTH      64        DQ bus width; user data is 2*DQ_WIDTH per beat
//  DM_WIDTH      8         DM width; mask is 2*DM_WIDTH per beat
//  ADDR_WIDTH    31        address bits driven on app_af_addr[ADDR_WIDTH-1:0]
//  NUM_CMDS      8         commands per batch, 1..255
//  ADDR_STEP     4         address increment per command
//  ADDR_LIMIT    2**20     base address wraps to 0 when next base >= ADDR_LIMIT
//  CNT_WIDTH     16        width of err_cnt and batch_cnt (saturating)
// PORTS
//  clk               in   1             controller user clock
//  reset_n           in   1             asynchronous, active-low reset
//  init_done         in   1             memory calibration complete
//  wdf_almost_full   in   1             write-data FIFO almost full
//  af_almost_full    in   1             address FIFO almost full
//  burst_length_div2 in   3             beats per burst (1..4); 0 treated as 1
//  read_data_valid   in   1             read beat valid
//  read_data_fifo_out in  2*DQ_WIDTH    read beat data
//  app_af_addr       out  36            [35:33] cmd (000 write, 001 read), [ADDR_WIDTH-1:0] address, rest 0
//  app_af_wren       out  1             address FIFO write strobe
//  app_wdf_data      out  2*DQ_WIDTH    write beat data
//  app_mask_data     out  2*DM_WIDTH    write mask, always 0
//  app_wdf_wren      out  1             write-data FIFO write strobe
//  error             out  1             sticky compare/unexpected-data error
//  err_cnt           out  CNT_WIDTH     failing beats, saturating
//  first_err_addr    out  ADDR_WIDTH    command address of first failing beat
//  batch_cnt         out  CNT_WIDTH     batches completed error-free, saturating
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs and counters 0, FSM IDLE, base address 0. Mid-operation reset aborts instantly.
//  - wdf_almost_full is registered once (wdf_af_r) before use. af_almost_full is used directly.
//  - FSM IDLE->WRITE->READ->WAIT_RD->IDLE. All outputs registered; one-cycle latency from state/flags.
//  - IDLE: leave when init_done & !wdf_af_r & !af_almost_full. Latch bl = max(burst_length_div2,1) for the whole batch.
//  - WRITE: each cycle with !wdf_af_r & !af_almost_full emits one beat (app_wdf_wren=1). Stalled cycles emit no strobes and keep the beat/cmd counters.
//    - The last beat of each burst also asserts app_af_wren with cmd 000 and address base+k*ADDR_STEP.
//    - After NUM_CMDS commands go to READ.
//  - READ: one read command (cmd 001, same address sequence) per cycle with !af_almost_full. After NUM_CMDS go to WAIT_RD.
//  - WAIT_RD: stay until NUM_CMDS*bl beats are received.
//    - On completion, batch_cnt++ if the batch had no error.
//    - Base address advances by NUM_CMDS*ADDR_STEP, wrapping to 0 at ADDR_LIMIT. Then go to IDLE.
//  - Checker: own command/beat counters replay the batch addresses in order. Each read_data_valid compares against regenerated data.
//    - On mismatch: error=1 (sticky), err_cnt++, and first_err_addr is loaded once.
//    - A beat arriving while no beats are outstanding counts as a mismatch.
//    - Reads may be accepted in any state once issued. The checker runs concurrently with READ.
//  - Data pattern word w(a,b) for address a and beat b (0..bl-1) is 32 bits, replicated and truncated to 2*DQ_WIDTH.
//  - Address/beat arithmetic is modulo 2**ADDR_WIDTH. Counters saturate at all-ones.
// CONFIGURATION
//  - TG_PRBS_DATA_EN defined: w is a 32-bit Fibonacci LFSR (taps 32,22,2,1).
//    - Seeded with {a,1'b1} truncated to 32 bits at beat 0 of each command, advanced once per beat.
//    - Write and checker copies are identical.
//  - Undefined: w = a + b (zero-extended to 32). No LFSR logic.
// TESTING
//  1. NUM_CMDS=8, bl=2, flags low, loopback memory model:
//     -> 16 wdf strobes, 8 write cmds at addr 0,4,..,28, 8 read cmds, then batch_cnt=1, error=0, next base 32.
//  2. wdf_almost_full high for 5 cycles mid-WRITE:
//     -> strobes stop 2 cycles after assertion (register plus output), no beat is lost or duplicated, data sequence is continuous.
//  3. Model corrupts bit 0 of beat 1 of cmd 3 (addr 12):
//     -> error=1, err_cnt=1, first_err_addr=12, batch_cnt stays 0, error stays high afterwards.
//  4. ADDR_LIMIT=64, NUM_CMDS=8, ADDR_STEP=4: after batches at base 0 and 32, the third batch base is 0.
//  5. Extra read_data_valid pulse in IDLE -> err_cnt increments, error=1.
//  6. reset_n low during WAIT_RD -> all outputs 0 immediately; after release with init_done=1, the batch restarts at addr 0.
//     Run with and without TG_PRBS_DATA_EN.

Source files
------------

// File: rtl/ddr2_traffic_gen_if.sv
// rtl/ddr2_traffic_gen_if.sv - DDR2 user-interface FIFO flags, command/write-data and read-return signals
interface ddr2_traffic_gen_if #(
    parameter int DQ_WIDTH = 64,
    parameter int DM_WIDTH = 8
);
    logic                    wdf_almost_full;
    logic                    af_almost_full;
    logic                    read_data_valid;
    logic [2*DQ_WIDTH-1:0]   read_data_fifo_out;
    logic [35:0]             app_af_addr;
    logic                    app_af_wren;
    logic [2*DQ_WIDTH-1:0]   app_wdf_data;
    logic [2*DM_WIDTH-1:0]   app_mask_data;
    logic                    app_wdf_wren;

    modport master (
        input  wdf_almost_full, af_almost_full, read_data_valid, read_data_fifo_out,
        output app_af_addr, app_af_wren, app_wdf_data, app_mask_data, app_wdf_wren
    );

    modport slave (
        output wdf_almost_full, af_almost_full, read_data_valid, read_data_fifo_out,
        input  app_af_addr, app_af_wren, app_wdf_data, app_mask_data, app_wdf_wren
    );
endinterface

// File: rtl/ddr2_traffic_gen.sv
// rtl/ddr2_traffic_gen.sv - DDR2 batch write/read-back traffic generator and checker
// Define TG_PRBS_DATA_EN for LFSR data words; otherwise word = address + beat.
module ddr2_traffic_gen #(
    parameter int              DQ_WIDTH   = 64,
    parameter int              DM_WIDTH   = 8,
    parameter int              ADDR_WIDTH = 31,
    parameter int              NUM_CMDS   = 8,
    parameter int              ADDR_STEP  = 4,
    parameter longint unsigned ADDR_LIMIT = 64'd1 << 20,
    parameter int              CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_done,
    input  logic [2:0]            burst_length_div2,
    ddr2_traffic_gen_if.master    ui,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [CNT_WIDTH-1:0]  batch_cnt
);
    localparam int                    DW       = 2 * DQ_WIDTH;
    localparam int                    RW       = ((DW + 31) / 32) * 32;
    localparam int                    PW       = 11;
    localparam logic [2:0]            CMD_WR   = 3'b000;
    localparam logic [2:0]            CMD_RD   = 3'b001;
    localparam logic [7:0]            LAST_CMD = 8'(NUM_CMDS - 1);
    localparam logic [7:0]            ALL_CMDS = 8'(NUM_CMDS);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD} state_t;

    function automatic logic [DW-1:0] replicate(input logic [31:0] w);
        logic [RW-1:0] wide;
        wide = {(RW / 32){w}};
        return wide[DW-1:0];
    endfunction

    function automatic logic [35:0] cmd_word(input logic [2:0] cmd, input logic [ADDR_WIDTH-1:0] a);
        logic [35:0] r;
        r = '0;
        r[ADDR_WIDTH-1:0] = a;
        r[35:33] = cmd;
        return r;
    endfunction

    state_t                state_q, state_d;
    logic                  wdf_af_q;
    logic [2:0]            bl_q, bl_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, chk_addr_q, chk_addr_d;
    logic [7:0]            wr_cmd_q, wr_cmd_d, rd_cmd_q, rd_cmd_d, chk_cmd_q, chk_cmd_d;
    logic [2:0]            wr_beat_q, wr_beat_d, chk_beat_q, chk_beat_d;
    logic [PW-1:0]         pend_q, pend_d;
    logic                  batch_err_q, batch_err_d;
    logic [35:0]           af_addr_q, af_addr_d;
    logic                  af_wren_q, af_wren_d, wdf_wren_q, wdf_wren_d;
    logic [DW-1:0]         wdf_data_q, wdf_data_d;
    logic                  error_q, error_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, batch_cnt_q, batch_cnt_d;
    logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;

    logic                  start, wr_fire, wr_last_beat, wr_cmd_done, rd_fire, rd_cmd_done;
    logic                  chk_take, chk_last_beat, mismatch, batch_done;
    logic [63:0]           base_sum;
    logic [ADDR_WIDTH-1:0] next_base;
    logic [31:0]           wr_w, chk_w;

`ifdef TG_PRBS_DATA_EN
    logic [31:0] wr_lfsr_q, wr_lfsr_d, chk_lfsr_q, chk_lfsr_d;

    function automatic logic [31:0] lfsr_seed(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] s;
        s = {a, 1'b1};
        return 32'(s);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Beat 0 restarts from the address seed so write and check streams stay aligned per command.
    always_comb begin
        wr_w       = (wr_beat_q == 3'd0) ? lfsr_seed(wr_addr_q) : wr_lfsr_q;
        chk_w      = (chk_beat_q == 3'd0) ? lfsr_seed(chk_addr_q) : chk_lfsr_q;
        wr_lfsr_d  = wr_fire ? lfsr_step(wr_w) : wr_lfsr_q;
        chk_lfsr_d = chk_take ? lfsr_step(chk_w) : chk_lfsr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_lfsr_q  <= '0;
            chk_lfsr_q <= '0;
        end else begin
            wr_lfsr_q  <= wr_lfsr_d;
            chk_lfsr_q <= chk_lfsr_d;
        end
    end
`else
    function automatic logic [31:0] plain_word(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] b);
        logic [ADDR_WIDTH-1:0] s;
        s = a + ADDR_WIDTH'(b);
        return 32'(s);
    endfunction

    always_comb begin
        wr_w  = plain_word(wr_addr_q, wr_beat_q);
        chk_w = plain_word(chk_addr_q, chk_beat_q);
    end
`endif

    always_comb begin
        start         = (state_q == S_IDLE) && init_done && !wdf_af_q && !ui.af_almost_full;
        wr_fire       = (state_q == S_WRITE) && !wdf_af_q && !ui.af_almost_full;
        wr_last_beat  = (wr_beat_q == bl_q - 3'd1);
        wr_cmd_done   = wr_fire && wr_last_beat && (wr_cmd_q == LAST_CMD);
        rd_fire       = (state_q == S_READ) && !ui.af_almost_full;
        rd_cmd_done   = rd_fire && (rd_cmd_q == LAST_CMD);
        chk_take      = ui.read_data_valid && (pend_q != '0);
        chk_last_beat = (chk_beat_q == bl_q - 3'd1);
        // A beat with nothing outstanding is an error regardless of its contents.
        mismatch      = ui.read_data_valid && (!chk_take || (ui.read_data_fifo_out != replicate(chk_w)));
        batch_done    = (state_q == S_WAIT_RD) && (chk_cmd_q == ALL_CMDS);
        base_sum      = 64'(base_q) + 64'(NUM_CMDS) * 64'(ADDR_STEP);
        next_base     = (base_sum >= ADDR_LIMIT) ? '0 : ADDR_WIDTH'(base_sum);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)       state_d = S_WRITE;
            S_WRITE:   if (wr_cmd_done) state_d = S_READ;
            S_READ:    if (rd_cmd_done) state_d = S_WAIT_RD;
            S_WAIT_RD: if (batch_done)  state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bl_d             = bl_q;
        base_d           = base_q;
        wr_addr_d        = wr_addr_q;
        rd_addr_d        = rd_addr_q;
        chk_addr_d       = chk_addr_q;
        wr_cmd_d         = wr_cmd_q;
        rd_cmd_d         = rd_cmd_q;
        chk_cmd_d        = chk_cmd_q;
        wr_beat_d        = wr_beat_q;
        chk_beat_d       = chk_beat_q;
        batch_err_d      = batch_err_q;
        af_addr_d        = af_addr_q;
        af_wren_d        = 1'b0;
        wdf_wren_d       = 1'b0;
        wdf_data_d       = wdf_data_q;
        error_d          = error_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        batch_cnt_d      = batch_cnt_q;
        pend_d           = pend_q + (rd_fire ? PW'(bl_q) : '0) - (chk_take ? PW'(1) : '0);

        if (wr_fire) begin
            wdf_wren_d = 1'b1;
            wdf_data_d = replicate(wr_w);
            if (wr_last_beat) begin
                af_wren_d = 1'b1;
                af_addr_d = cmd_word(CMD_WR, wr_addr_q);
                wr_beat_d = 3'd0;
                wr_cmd_d  = wr_cmd_q + 8'd1;
                wr_addr_d = wr_addr_q + STEP;
            end else begin
                wr_beat_d = wr_beat_q + 3'd1;
            end
        end

        if (rd_fire) begin
            af_wren_d = 1'b1;
            af_addr_d = cmd_word(CMD_RD, rd_addr_q);
            rd_cmd_d  = rd_cmd_q + 8'd1;
            rd_addr_d = rd_addr_q + STEP;
        end

        if (chk_take) begin
            if (chk_last_beat) begin
                chk_beat_d = 3'd0;
                chk_cmd_d  = chk_cmd_q + 8'd1;
                chk_addr_d = chk_addr_q + STEP;
            end else begin
                chk_beat_d = chk_beat_q + 3'd1;
            end
        end

        if (mismatch) begin
            error_d     = 1'b1;
            batch_err_d = 1'b1;
            err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
            if (!error_q) first_err_addr_d = chk_addr_q;
        end

        // Stray beats seen while idle do not disqualify the batch that starts next.
        if (start) begin
            bl_d        = (burst_length_div2 == 3'd0) ? 3'd1 : burst_length_div2;
            batch_err_d = 1'b0;
        end

        if (batch_done) begin
            if (!batch_err_q && !mismatch)
                batch_cnt_d = (batch_cnt_q == '1) ? batch_cnt_q : batch_cnt_q + 1'b1;
            base_d     = next_base;
            wr_addr_d  = next_base;
            rd_addr_d  = next_base;
            chk_addr_d = next_base;
            wr_cmd_d   = 8'd0;
            rd_cmd_d   = 8'd0;
            chk_cmd_d  = 8'd0;
            wr_beat_d  = 3'd0;
            chk_beat_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            wdf_af_q         <= 1'b0;
            bl_q             <= 3'd1;
            base_q           <= '0;
            wr_addr_q        <= '0;
            rd_addr_q        <= '0;
            chk_addr_q       <= '0;
            wr_cmd_q         <= '0;
            rd_cmd_q         <= '0;
            chk_cmd_q        <= '0;
            wr_beat_q        <= '0;
            chk_beat_q       <= '0;
            pend_q           <= '0;
            batch_err_q      <= 1'b0;
            af_addr_q        <= '0;
            af_wren_q        <= 1'b0;
            wdf_wren_q       <= 1'b0;
            wdf_data_q       <= '0;
            error_q          <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            batch_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            wdf_af_q         <= ui.wdf_almost_full;
            bl_q             <= bl_d;
            base_q           <= base_d;
            wr_addr_q        <= wr_addr_d;
            rd_addr_q        <= rd_addr_d;
            chk_addr_q       <= chk_addr_d;
            wr_cmd_q         <= wr_cmd_d;
            rd_cmd_q         <= rd_cmd_d;
            chk_cmd_q        <= chk_cmd_d;
            wr_beat_q        <= wr_beat_d;
            chk_beat_q       <= chk_beat_d;
            pend_q           <= pend_d;
            batch_err_q      <= batch_err_d;
            af_addr_q        <= af_addr_d;
            af_wren_q        <= af_wren_d;
            wdf_wren_q       <= wdf_wren_d;
            wdf_data_q       <= wdf_data_d;
            error_q          <= error_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            batch_cnt_q      <= batch_cnt_d;
        end
    end

    assign ui.app_af_addr   = af_addr_q;
    assign ui.app_af_wren   = af_wren_q;
    assign ui.app_wdf_data  = wdf_data_q;
    assign ui.app_wdf_wren  = wdf_wren_q;
    assign ui.app_mask_data = {(2 * DM_WIDTH){1'b0}};
    assign error            = error_q;
    assign err_cnt          = err_cnt_q;
    assign first_err_addr   = first_err_addr_q;
    assign batch_cnt        = batch_cnt_q;
endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// tb/tb_ddr2_traffic_gen.sv - loopback-memory bench for ddr2_traffic_gen with a batch-level reference model
module tb_ddr2_traffic_gen;
    localparam int DQW  = 64;
    localparam int DMW  = 8;
    localparam int AW   = 31;
    localparam int NCMD = 8;
    localparam int STEP = 4;
    localparam int DW   = 2 * DQW;

    logic        clk, reset_n, init_done;
    logic [2:0]  burst_length_div2;
    logic        error;
    logic [15:0] err_cnt, batch_cnt;
    logic [AW-1:0] first_err_addr;

    ddr2_traffic_gen_if #(.DQ_WIDTH(DQW), .DM_WIDTH(DMW)) ui ();

    ddr2_traffic_gen #(
        .DQ_WIDTH(DQW), .DM_WIDTH(DMW), .ADDR_WIDTH(AW), .NUM_CMDS(NCMD),
        .ADDR_STEP(STEP), .ADDR_LIMIT(64), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_done(init_done),
        .burst_length_div2(burst_length_div2), .ui(ui),
        .error(error), .err_cnt(err_cnt), .first_err_addr(first_err_addr), .batch_cnt(batch_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] wdf_obs[$];
    logic [35:0]   cmd_obs[$];
    logic [DW-1:0] rsp_q[$];
    logic [DW-1:0] mem_pend[$];
    logic [DW-1:0] mem [longint];
    int wdf_idx = 0, cmd_idx = 0, pend_idx = 0, rsp_idx = 0;
    int beats_sent = 0, stray_req = 0, stray_done = 0;
    int cur_bl = 2;
    bit hold_rsp = 0, corrupt_en = 0, rand_af_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input longint a, input int b);
        logic [31:0] s;
`ifdef TG_PRBS_DATA_EN
        s = 32'(a * 2 + 1);
        for (int i = 0; i < b; i++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
`else
        s = 32'((a + longint'(b)) % (64'sd1 <<< AW));
`endif
        return s;
    endfunction

    function automatic logic [DW-1:0] beat_of(input longint a, input int b);
        return {(DW / 32){word_of(a, b)}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loopback memory: write bursts land at their command address, read commands queue the stored beats.
    initial begin
        longint a;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend_idx = mem_pend.size();
            end else begin
                if (ui.app_wdf_wren) begin
                    wdf_obs.push_back(ui.app_wdf_data);
                    mem_pend.push_back(ui.app_wdf_data);
                end
                if (ui.app_af_wren) begin
                    cmd_obs.push_back(ui.app_af_addr);
                    a = longint'(ui.app_af_addr[AW-1:0]);
                    for (int b = 0; b < cur_bl; b++) begin
                        if (ui.app_af_addr[35:33] == 3'b000) begin
                            mem[a * 8 + b] = (pend_idx < mem_pend.size()) ? mem_pend[pend_idx] : '0;
                            pend_idx++;
                        end else begin
                            d = mem.exists(a * 8 + b) ? mem[a * 8 + b] : '0;
                            if (corrupt_en && a == 12 && b == 1) d[0] = ~d[0];
                            rsp_q.push_back(d);
                        end
                    end
                end
            end
        end
    end

    initial begin
        ui.read_data_valid    = 1'b0;
        ui.read_data_fifo_out = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                rsp_idx = rsp_q.size();
                ui.read_data_valid = 1'b0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                ui.read_data_valid    = 1'b1;
                ui.read_data_fifo_out = {4{$urandom()}};
            end else if (!hold_rsp && rsp_idx < rsp_q.size() && $urandom_range(0, 3) != 0) begin
                ui.read_data_valid    = 1'b1;
                ui.read_data_fifo_out = rsp_q[rsp_idx];
                rsp_idx++;
                beats_sent++;
            end else begin
                ui.read_data_valid = 1'b0;
            end
        end
    end

    initial begin
        ui.af_almost_full = 1'b0;
        forever begin
            @(posedge clk); #1;
            ui.af_almost_full = rand_af_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    task automatic wait_first_strobe();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            seen = ui.app_wdf_wren;
        end
    endtask

    task automatic wait_batch(input int beats);
        int s0 = beats_sent;
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            done = (cmd_obs.size() - cmd_idx >= 2 * NCMD) && (beats_sent - s0 >= beats);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_batch(input longint base, input int bl, input string tag);
        logic [DW-1:0] wd;
        logic [35:0]   cw;
        longint        a;
        for (int k = 0; k < NCMD; k++) begin
            a = (base + longint'(k * STEP)) % (64'sd1 <<< AW);
            for (int b = 0; b < bl; b++) begin
                wd = (wdf_idx < wdf_obs.size()) ? wdf_obs[wdf_idx] : 'x;
                wdf_idx++;
                chk({tag, "_wdata"}, 128'(wd), 128'(beat_of(a, b)));
            end
        end
        chk({tag, "_extra_beats"}, 128'(wdf_obs.size() - wdf_idx), 128'(0));
        for (int k = 0; k < 2 * NCMD; k++) begin
            a = (base + longint'((k % NCMD) * STEP)) % (64'sd1 <<< AW);
            cw = (cmd_idx < cmd_obs.size()) ? cmd_obs[cmd_idx] : 'x;
            cmd_idx++;
            chk({tag, (k < NCMD) ? "_wcmd" : "_rcmd"}, 128'(cw),
                128'({(k < NCMD) ? 3'b000 : 3'b001, 33'(a)}));
        end
        chk({tag, "_extra_cmds"}, 128'(cmd_obs.size() - cmd_idx), 128'(0));
    endtask

    initial begin
        int r;
        reset_n = 1'b0;
        init_done = 1'b0;
        burst_length_div2 = 3'd2;
        ui.wdf_almost_full = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_error", 128'(error), 128'(0));
        chk("rst_err_cnt", 128'(err_cnt), 128'(0));
        chk("rst_first_err", 128'(first_err_addr), 128'(0));
        chk("rst_batch_cnt", 128'(batch_cnt), 128'(0));
        chk("rst_af_wren", 128'(ui.app_af_wren), 128'(0));
        chk("rst_wdf_wren", 128'(ui.app_wdf_wren), 128'(0));
        chk("rst_af_addr", 128'(ui.app_af_addr), 128'(0));
        chk("rst_wdf_data", 128'(ui.app_wdf_data), 128'(0));
        chk("mask_zero", 128'(ui.app_mask_data), 128'(0));
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_init_idle", 128'(ui.app_af_wren | ui.app_wdf_wren), 128'(0));

        // Batch 1: bl=2 with a five-cycle write-data FIFO stall in the middle of WRITE.
        cur_bl = 2;
        init_done = 1'b1;
        wait_first_strobe();
        init_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 ui.wdf_almost_full = 1'b1;
        @(posedge clk); #1 chk("stall_lag", 128'(ui.app_wdf_wren), 128'(1));
        @(posedge clk); #1 chk("stall_stop", 128'(ui.app_wdf_wren), 128'(0));
        repeat (3) begin
            @(posedge clk); #1 chk("stall_hold", 128'(ui.app_wdf_wren), 128'(0));
        end
        ui.wdf_almost_full = 1'b0;
        @(posedge clk); #1 chk("stall_tail", 128'(ui.app_wdf_wren), 128'(0));
        @(posedge clk); #1 chk("stall_resume", 128'(ui.app_wdf_wren), 128'(1));
        wait_batch(NCMD * cur_bl);
        check_batch(0, 2, "b1");
        chk("b1_batch_cnt", 128'(batch_cnt), 128'(1));
        chk("b1_error", 128'(error), 128'(0));

        // Batch 2: random burst length (0 means 1) and random address-FIFO back-pressure.
        r = $urandom_range(0, 4);
        burst_length_div2 = 3'(r);
        cur_bl = (r == 0) ? 1 : r;
        rand_af_en = 1;
        init_done = 1'b1;
        wait_first_strobe();
        init_done = 1'b0;
        wait_batch(NCMD * cur_bl);
        rand_af_en = 0;
        check_batch(32, cur_bl, "b2");
        chk("b2_batch_cnt", 128'(batch_cnt), 128'(2));
        chk("b2_err_cnt", 128'(err_cnt), 128'(0));

        // Batch 3: base wraps to 0 at the 64 limit; beat 1 of the addr-12 command is corrupted.
        burst_length_div2 = 3'd2;
        cur_bl = 2;
        corrupt_en = 1;
        init_done = 1'b1;
        wait_first_strobe();
        init_done = 1'b0;
        wait_batch(NCMD * cur_bl);
        corrupt_en = 0;
        check_batch(0, 2, "b3");
        chk("b3_error", 128'(error), 128'(1));
        chk("b3_err_cnt", 128'(err_cnt), 128'(1));
        chk("b3_first_err", 128'(first_err_addr), 128'(12));
        chk("b3_batch_cnt", 128'(batch_cnt), 128'(2));

        // Stray read beat while idle.
        stray_req++;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_err_cnt", 128'(err_cnt), 128'(2));
        chk("stray_error", 128'(error), 128'(1));
        chk("stray_first_err", 128'(first_err_addr), 128'(12));

        // Batch 4 is aborted by reset while waiting for read data.
        hold_rsp = 1;
        init_done = 1'b1;
        wait_first_strobe();
        init_done = 1'b0;
        for (int i = 0; i < 500 && (cmd_obs.size() - cmd_idx < 2 * NCMD); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("b4_first_wcmd", 128'((cmd_idx < cmd_obs.size()) ? cmd_obs[cmd_idx] : 36'h0), 128'(32));
        chk("b4_read_cmds", 128'(cmd_obs.size() - cmd_idx), 128'(2 * NCMD));
        #1 reset_n = 1'b0;
        #2;
        chk("arst_error", 128'(error), 128'(0));
        chk("arst_err_cnt", 128'(err_cnt), 128'(0));
        chk("arst_first_err", 128'(first_err_addr), 128'(0));
        chk("arst_batch_cnt", 128'(batch_cnt), 128'(0));
        chk("arst_af_wren", 128'(ui.app_af_wren), 128'(0));
        chk("arst_af_addr", 128'(ui.app_af_addr), 128'(0));
        chk("arst_wdf_wren", 128'(ui.app_wdf_wren), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        hold_rsp = 0;
        wdf_idx = wdf_obs.size();
        cmd_idx = cmd_obs.size();
        reset_n = 1'b1;
        init_done = 1'b1;
        wait_first_strobe();
        init_done = 1'b0;
        wait_batch(NCMD * cur_bl);
        check_batch(0, 2, "b5");
        chk("b5_batch_cnt", 128'(batch_cnt), 128'(1));
        chk("b5_error", 128'(error), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
